// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- registered, handshaked N-bit ALU with status flags.
//
// Successor of the combinational 2-bit-opcode ALU: the original codes keep
// their meaning (000 ADD, 001 OR, 010 SUB, 011 XOR) and the opcode grows to
// three bits (100 AND, 101 SLT, 110 SLTU, 111 MUL or XOR).
//
// Optional feature macro: ALU_MUL_EN
//   defined   : opcode 111 is an unsigned W-cycle shift-add multiply
//               (low W product bits, flag_c = upper half non-zero).
//   undefined : opcode 111 is a single-cycle XOR, busy is tied low.
//
// Parameters
//   W    operand/result width (>= 2)
//   OPW  opcode width (fixed at 3)
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, opcode sampled on transfer)
//   a, b, opcode         operands and operation select
//   out_valid/out_ready  result handshake (out and flags held until taken)
//   out                  registered result
//   flag_z, flag_c,      zero, carry / no-borrow, signed overflow
//   flag_v
//   busy                 iterative multiply in progress
// ---------------------------------------------------------------------------
module alu_pipe #(
   parameter int W   = 8,
   parameter int OPW = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [OPW-1:0] opcode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out,
   output logic           flag_z,
   output logic           flag_c,
   output logic           flag_v,
   output logic           busy
);

   localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
   localparam logic [OPW-1:0] OP_OR   = OPW'(1);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(3);
   localparam logic [OPW-1:0] OP_AND  = OPW'(4);
   localparam logic [OPW-1:0] OP_SLT  = OPW'(5);
   localparam logic [OPW-1:0] OP_SLTU = OPW'(6);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(7);

   logic         in_xfer;
   logic         out_xfer;
   logic         is_mul;
   logic         load_single;
   logic         mul_done;
   logic [W-1:0] mul_res;
   logic         mul_c;

   logic [W:0]   sum_ext;
   logic [W:0]   diff_ext;
   logic [W-1:0] alu_res;
   logic         alu_c;
   logic         alu_v;

   assign in_xfer     = in_valid & in_ready;
   assign out_xfer    = out_valid & out_ready;
   assign load_single = in_xfer & ~is_mul;

   // ------------------------------------------------------------------------
   // Single-cycle datapath
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      sum_ext  = {1'b0, a} + {1'b0, b};
      diff_ext = {1'b0, a} - {1'b0, b};
      case (opcode)
         OP_ADD: begin
            alu_res = sum_ext[W-1:0];
            alu_c   = sum_ext[W];
            // Overflow: like-signed operands giving an opposite-signed sum.
            alu_v   = (a[W-1] == b[W-1]) && (sum_ext[W-1] != a[W-1]);
         end
         OP_OR:   alu_res = a | b;
         OP_SUB: begin
            alu_res = diff_ext[W-1:0];
            // Top bit of the extended difference is the borrow.
            alu_c   = ~diff_ext[W];
            alu_v   = (a[W-1] != b[W-1]) && (diff_ext[W-1] != a[W-1]);
         end
         OP_XOR:  alu_res = a ^ b;
         OP_AND:  alu_res = a & b;
         OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_res = {{(W-1){1'b0}}, (a < b)};
         // Legacy default branch: 111 is XOR when no multiplier is built.
         default: alu_res = a ^ b;
      endcase
   end

`ifdef ALU_MUL_EN
   // ------------------------------------------------------------------------
   // Iterative shift-add multiplier and its control FSM
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_HOLD
   } state_e;

   localparam int CW = $clog2(W);

   state_e         state;
   state_e         state_nxt;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] mcand;
   logic [2*W-1:0] acc_step;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  cnt;
   logic           mul_start;
   logic           last_iter;

   assign is_mul    = (opcode == OP_MUL);
   assign mul_start = in_xfer & is_mul;
   assign last_iter = (cnt == CW'(W-1));
   assign mul_done  = (state == ST_MUL) && last_iter;
   assign in_ready  = (state == ST_IDLE) & (~out_valid | out_ready);
   assign busy      = (state == ST_MUL);

   // One partial product per cycle; the last one is folded in
   // combinationally so the result can be registered on the W-th MUL edge.
   assign acc_step  = acc + (mplier[0] ? mcand : '0);
   assign mul_res   = acc_step[W-1:0];
   assign mul_c     = |acc_step[2*W-1:W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (mul_start) state_nxt = ST_MUL;
         ST_MUL:  if (last_iter) state_nxt = ST_HOLD;
         // out_valid is always set here, so out_ready alone means "taken".
         ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the multiplier working registers are reset as well, so an
      // aborted multiply cannot leave a partial product that leaks later.
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (mul_start) begin
         acc    <= '0;
         mcand  <= {{W{1'b0}}, a};
         mplier <= b;
         cnt    <= '0;
      end else if (state == ST_MUL) begin
         acc    <= acc_step;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end
`else
   assign is_mul   = 1'b0;
   assign mul_done = 1'b0;
   assign mul_res  = '0;
   assign mul_c    = 1'b0;
   assign in_ready = ~out_valid | out_ready;
   assign busy     = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Result register: loaded on a single-cycle accept or a finished
   // multiply, otherwise held until the consumer takes it.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values
      // regardless of statement order.
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         flag_v    <= 1'b0;
      end else if (load_single) begin
         // Also covers a simultaneous output transfer: the new result
         // replaces the old one and out_valid stays high.
         out_valid <= 1'b1;
         out       <= alu_res;
         flag_z    <= (alu_res == '0);
         flag_c    <= alu_c;
         flag_v    <= alu_v;
      end else if (mul_done) begin
         out_valid <= 1'b1;
         out       <= mul_res;
         flag_z    <= (mul_res == '0);
         flag_c    <= mul_c;
         flag_v    <= 1'b0;
      end else if (out_xfer) begin
         out_valid <= 1'b0;
      end
   end

endmodule
